// File: rtl/myfilter_pkg.sv
// Shared filter datapath types: the ALU command set and the SATA reference saturation
// function for the default 16-bit data / 40-bit accumulator geometry.
package myfilter_pkg;

  typedef enum logic [4:0] {
    NOP  = 5'd0,
    M1   = 5'd1,
    M2   = 5'd2,
    MU   = 5'd3,
    ACN  = 5'd4,
    M1N  = 5'd5,
    M2N  = 5'd6,
    MUN  = 5'd7,
    ADAC = 5'd8,
    ADM1 = 5'd9,
    ADM2 = 5'd10,
    ADMU = 5'd11,
    SUAC = 5'd12,
    SUM1 = 5'd13,
    SUM2 = 5'd14,
    SUMU = 5'd15,
    SATA = 5'd16
  } alu_cmd_t;

  localparam int SAT_DATABITS = 16;
  localparam int SAT_ACCBITS  = 40;

  // Reference SATA at the default geometry; round adds half an output LSB first.
  function automatic logic [SAT_ACCBITS-1:0] sat_q(input logic [SAT_ACCBITS-1:0] acc,
                                                   input logic round);
    logic [SAT_ACCBITS:0]                     r;
    logic [SAT_ACCBITS-2*SAT_DATABITS+2:0]    op;
    logic [SAT_DATABITS-1:0]                  ip;
    r = {acc[SAT_ACCBITS-1], acc};
    if (round) r = r + ((SAT_ACCBITS+1)'(1) << (SAT_DATABITS-2));
    op = r[SAT_ACCBITS:2*SAT_DATABITS-2];
    ip = r[2*SAT_DATABITS-2:SAT_DATABITS-1];
    if (!r[SAT_ACCBITS] && (|op))
      sat_q = {{(SAT_ACCBITS-SAT_DATABITS+1){1'b0}}, {(SAT_DATABITS-1){1'b1}}};
    else if (r[SAT_ACCBITS] && !(&op))
      sat_q = {{(SAT_ACCBITS-SAT_DATABITS+1){1'b1}}, {(SAT_DATABITS-1){1'b0}}};
    else
      sat_q = {{(SAT_ACCBITS-SAT_DATABITS){ip[SAT_DATABITS-1]}}, ip};
  endfunction

endpackage

// File: rtl/mac_alu_sat.sv
// Combinational SATA unit: extracts the DATABITS output window of the accumulator and
// saturates it. Define ALU_ROUND_EN to round half up before saturating.
module mac_alu_sat #(
  parameter int DATABITS = 16,
  parameter int ACCBITS  = 40
) (
  input  logic [ACCBITS-1:0] acc,
  output logic [ACCBITS-1:0] q
);

  localparam logic [ACCBITS:0] HALF = (ACCBITS+1)'(1) << (DATABITS-2);

  logic [ACCBITS:0]              r;
  logic [ACCBITS-2*DATABITS+2:0] op;
  logic [DATABITS-1:0]           ip;

  always_comb begin
    // One extra bit so a rounding carry out of the top stays positive.
`ifdef ALU_ROUND_EN
    r = {acc[ACCBITS-1], acc} + HALF;
`else
    r = {acc[ACCBITS-1], acc};
`endif
    op = r[ACCBITS:2*DATABITS-2];
    ip = r[2*DATABITS-2:DATABITS-1];
    if (!r[ACCBITS] && (|op))
      q = {{(ACCBITS-DATABITS+1){1'b0}}, {(DATABITS-1){1'b1}}};
    else if (r[ACCBITS] && !(&op))
      q = {{(ACCBITS-DATABITS+1){1'b1}}, {(DATABITS-1){1'b0}}};
    else
      q = {{(ACCBITS-DATABITS){ip[DATABITS-1]}}, ip};
  end

  logic unused_half;
  assign unused_half = ^HALF;

endmodule

// File: rtl/mac_alu_pipe.sv
// Two-stage pipelined MAC/ALU with internal accumulator, valid/ready flow control,
// synchronous clear and sticky overflow. Define ALU_ROUND_EN to round before SATA.
module mac_alu_pipe
  import myfilter_pkg::*;
#(
  parameter int DATABITS = 16,
  parameter int ACCBITS  = 40
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  alu_cmd_t            cmd_in,
  input  logic [DATABITS-1:0] m1_in,
  input  logic [DATABITS-1:0] m2_in,
  input  logic                clr_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACCBITS-1:0]  d_out,
  output logic                ovf_out
);

  localparam int XW = ACCBITS + 2;

  if (ACCBITS < 2*DATABITS+1) begin : g_bad_accbits
    $error("mac_alu_pipe: ACCBITS must be at least 2*DATABITS+1");
  end

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // The whole pipe advances together (en) unless a retired result is still unconsumed,
  // so in_ready never looks at in_valid.
  logic en;
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  logic                  s1_valid;
  alu_cmd_t              s1_cmd;
  logic [DATABITS-1:0]   s1_m1, s1_m2;
  logic [2*DATABITS-1:0] s1_p, prod;

  assign prod = $signed({{DATABITS{m1_in[DATABITS-1]}}, m1_in})
              * $signed({{DATABITS{m2_in[DATABITS-1]}}, m2_in});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_cmd   <= NOP;
      s1_m1    <= '0;
      s1_m2    <= '0;
      s1_p     <= '0;
    end else if (en) begin
      s1_valid <= in_valid && in_ready;
      s1_cmd   <= cmd_in;
      s1_m1    <= m1_in;
      s1_m2    <= m2_in;
      s1_p     <= prod;
    end
  end

  logic [ACCBITS-1:0] acc_base, sat_res;
  logic [XW-1:0]      acc_x, m1_x, m2_x, p_x, res_x;
  logic               ovf_hit;

  mac_alu_sat #(.DATABITS(DATABITS), .ACCBITS(ACCBITS)) u_sat (
    .acc (acc_base),
    .q   (sat_res)
  );

  // Exact result at ACCBITS+2 bits; overflow when the top three bits disagree.
  always_comb begin
    acc_base = clr_in ? '0 : d_out;
    acc_x    = {{2{acc_base[ACCBITS-1]}}, acc_base};
    m1_x     = {{(XW-DATABITS){s1_m1[DATABITS-1]}}, s1_m1};
    m2_x     = {{(XW-DATABITS){s1_m2[DATABITS-1]}}, s1_m2};
    p_x      = {{(XW-2*DATABITS){s1_p[2*DATABITS-1]}}, s1_p};
    case (s1_cmd)
      NOP:     res_x = acc_x;
      M1:      res_x = m1_x;
      M2:      res_x = m2_x;
      MU:      res_x = p_x;
      ACN:     res_x = -acc_x;
      M1N:     res_x = -m1_x;
      M2N:     res_x = -m2_x;
      MUN:     res_x = -p_x;
      ADAC:    res_x = acc_x + acc_x;
      ADM1:    res_x = acc_x + m1_x;
      ADM2:    res_x = acc_x + m2_x;
      ADMU:    res_x = acc_x + p_x;
      SUAC:    res_x = '0;
      SUM1:    res_x = acc_x - m1_x;
      SUM2:    res_x = acc_x - m2_x;
      SUMU:    res_x = acc_x - p_x;
      SATA:    res_x = {{2{sat_res[ACCBITS-1]}}, sat_res};
      default: res_x = acc_x;
    endcase
    ovf_hit = (res_x[XW-1:ACCBITS-1] != 3'b000) && (res_x[XW-1:ACCBITS-1] != 3'b111);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      d_out     <= '0;
      ovf_out   <= 1'b0;
    end else if (en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        d_out   <= res_x[ACCBITS-1:0];
        ovf_out <= (ovf_out && !clr_in) || ovf_hit;
      end else if (clr_in) begin
        d_out   <= '0;
        ovf_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_alu_pipe.sv
// Directed bench for mac_alu_pipe at DATABITS=16, ACCBITS=40: vector table plus
// hand sequences for overflow, stall and mid-flight reset.
module tb_mac_alu_pipe;
  import myfilter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  alu_cmd_t    cmd_in;
  logic [15:0] m1_in, m2_in;
  logic        clr_in;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] d_out;
  logic        ovf_out;

  int checks = 0;
  int errors = 0;

  logic [39:0] exp_q[$];

  mac_alu_pipe #(.DATABITS(16), .ACCBITS(40)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cmd_in    (cmd_in),
    .m1_in     (m1_in),
    .m2_in     (m2_in),
    .clr_in    (clr_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d_out     (d_out),
    .ovf_out   (ovf_out)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string       name;
    alu_cmd_t    cmd;
    logic [15:0] m1;
    logic [15:0] m2;
    logic        clr;
    logic [39:0] exp_d;
    logic        exp_o;
  } vec_t;

  vec_t vecs[26];

  task automatic check(input string nm, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Issue one command, assert clr_in on its retire edge if requested, wait for out_valid.
  task automatic run_cmd(input alu_cmd_t c, input logic [15:0] a, input logic [15:0] b,
                         input logic clr, output logic [39:0] d, output logic o,
                         output int lat);
    @(negedge clk);
    cmd_in = c; m1_in = a; m2_in = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; clr_in = clr;
    lat = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      clr_in = 1'b0;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    d = d_out;
    o = ovf_out;
  endtask

  task automatic run_check(input string nm, input alu_cmd_t c, input logic [15:0] a,
                           input logic [15:0] b, input logic clr,
                           input logic [39:0] exp_d, input logic exp_o);
    logic [39:0] d;
    logic        o;
    int          lat;
    run_cmd(c, a, b, clr, d, o, lat);
    check({nm, "_lat"}, 40'(lat), 40'd0);
    check({nm, "_d"}, d, exp_d);
    check({nm, "_ovf"}, 40'(o), 40'(exp_o));
  endtask

  initial begin
    logic [39:0] d, e, held_d;
    logic        o, held_v;
    int          lat, sent, got;

    vecs[0]  = '{"admu_neg",  ADMU, 16'h0003, 16'hFFFE, 1'b1, 40'hFFFFFFFFFA, 1'b0};
    vecs[1]  = '{"adm1",      ADM1, 16'h0010, 16'h0000, 1'b0, 40'h000000000A, 1'b0};
    vecs[2]  = '{"ld30_0",    ADMU, 16'h4000, 16'h4000, 1'b1, 40'h0010000000, 1'b0};
    vecs[3]  = '{"ld30_1",    ADMU, 16'h4000, 16'h4000, 1'b0, 40'h0020000000, 1'b0};
    vecs[4]  = '{"ld30_2",    ADMU, 16'h4000, 16'h4000, 1'b0, 40'h0030000000, 1'b0};
    vecs[5]  = '{"ld30_3",    ADMU, 16'h4000, 16'h4000, 1'b0, 40'h0040000000, 1'b0};
    vecs[6]  = '{"sata_pos",  SATA, 16'h0000, 16'h0000, 1'b0, 40'h0000007FFF, 1'b0};
    vecs[7]  = '{"ld31_0",    ADMU, 16'h8000, 16'h4000, 1'b1, 40'hFFE0000000, 1'b0};
    vecs[8]  = '{"ld31_1",    ADMU, 16'h8000, 16'h4000, 1'b0, 40'hFFC0000000, 1'b0};
    vecs[9]  = '{"ld31_2",    ADMU, 16'h8000, 16'h4000, 1'b0, 40'hFFA0000000, 1'b0};
    vecs[10] = '{"ld31_3",    ADMU, 16'h8000, 16'h4000, 1'b0, 40'hFF80000000, 1'b0};
    vecs[11] = '{"sata_neg",  SATA, 16'h0000, 16'h0000, 1'b0, 40'hFFFFFF8000, 1'b0};
    vecs[12] = '{"mu",        MU,   16'h0003, 16'h4000, 1'b0, 40'h000000C000, 1'b0};
    vecs[13] = '{"adac",      ADAC, 16'h0000, 16'h0000, 1'b0, 40'h0000018000, 1'b0};
    vecs[14] = '{"sata_ip",   SATA, 16'h0000, 16'h0000, 1'b0, 40'h0000000003, 1'b0};
    vecs[15] = '{"m2n",       M2N,  16'h0000, 16'h0007, 1'b0, 40'hFFFFFFFFF9, 1'b0};
    vecs[16] = '{"sumu",      SUMU, 16'h0002, 16'h0003, 1'b0, 40'hFFFFFFFFF3, 1'b0};
    vecs[17] = '{"suac",      SUAC, 16'h0000, 16'h0000, 1'b0, 40'h0000000000, 1'b0};
    vecs[18] = '{"adm2",      ADM2, 16'h0000, 16'hFFFF, 1'b0, 40'hFFFFFFFFFF, 1'b0};
    vecs[19] = '{"sum1",      SUM1, 16'h8000, 16'h0000, 1'b0, 40'h0000007FFF, 1'b0};
    vecs[20] = '{"acn",       ACN,  16'h0000, 16'h0000, 1'b0, 40'hFFFFFF8001, 1'b0};
    vecs[21] = '{"m1",        M1,   16'h4000, 16'h0000, 1'b0, 40'h0000004000, 1'b0};
`ifdef ALU_ROUND_EN
    vecs[22] = '{"sata_rnd",  SATA, 16'h0000, 16'h0000, 1'b0, 40'h0000000001, 1'b0};
`else
    vecs[22] = '{"sata_rnd",  SATA, 16'h0000, 16'h0000, 1'b0, 40'h0000000000, 1'b0};
`endif
    vecs[23] = '{"mun",       MUN,  16'h7FFF, 16'h7FFF, 1'b0, 40'hFFC000FFFF, 1'b0};
    vecs[24] = '{"adac2",     ADAC, 16'h0000, 16'h0000, 1'b0, 40'hFF8001FFFE, 1'b0};
    vecs[25] = '{"sum2",      SUM2, 16'h0000, 16'h8000, 1'b0, 40'hFF80027FFE, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; cmd_in = NOP; m1_in = '0; m2_in = '0;
    clr_in = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_d", d_out, 40'd0);
    check("rst_valid", 40'(out_valid), 40'd0);
    check("rst_ovf", 40'(ovf_out), 40'd0);
    check("rst_in_ready", 40'(in_ready), 40'd1);

    for (int i = 0; i < 26; i++)
      run_check(vecs[i].name, vecs[i].cmd, vecs[i].m1, vecs[i].m2, vecs[i].clr,
                vecs[i].exp_d, vecs[i].exp_o);

    // Overflow: build -2^39 by doubling, then negate it.
    run_check("m1n", M1N, 16'h4000, 16'h0000, 1'b1, 40'hFFFFFFC000, 1'b0);
    e = 40'hFFFFFFC000;
    for (int k = 0; k < 25; k++) begin
      run_cmd(ADAC, 16'h0000, 16'h0000, 1'b0, d, o, lat);
      e = e << 1;
    end
    check("chain_d", d, 40'h8000000000);
    check("chain_model", d, e);
    check("chain_ovf", 40'(o), 40'd0);
    run_check("acn_min", ACN, 16'h0000, 16'h0000, 1'b0, 40'h8000000000, 1'b1);
    run_check("ovf_sticky", NOP, 16'h0000, 16'h0000, 1'b0, 40'h8000000000, 1'b1);
    run_check("ovf_sticky2", ADM1, 16'h0001, 16'h0000, 1'b0, 40'h8000000001, 1'b1);
    run_check("ovf_clr", NOP, 16'h0000, 16'h0000, 1'b1, 40'h0000000000, 1'b0);
    run_check("adac_wrap_ld", M1, 16'h8000, 16'h0000, 1'b0, 40'hFFFFFF8000, 1'b0);

    // Stream 8 ADMU with a consumer stall on cycles 3..5.
    run_cmd(NOP, 16'h0000, 16'h0000, 1'b1, d, o, lat);
    exp_q.delete();
    e = '0; sent = 0; got = 0; held_v = 1'b0; held_d = '0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      @(negedge clk);
      if (held_v) begin
        check("stall_d_stable", d_out, held_d);
        check("stall_valid_stable", 40'(out_valid), 40'd1);
      end
      out_ready = !(cyc >= 3 && cyc <= 5);
      #1;
      if (out_valid && !out_ready) check("stall_in_ready", 40'(in_ready), 40'd0);
      held_v = out_valid && !out_ready;
      held_d = d_out;
      if (out_valid && out_ready) begin
        got++;
        if (exp_q.size() == 0) check("stream_extra", d_out, 40'hX);
        else check("stream_d", d_out, exp_q.pop_front());
      end
      if (sent < 8 && in_ready) begin
        cmd_in = ADMU; m1_in = 16'(sent + 1); m2_in = 16'(sent + 2); in_valid = 1'b1;
        e = e + 40'((sent + 1) * (sent + 2));
        exp_q.push_back(e);
        sent++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stream_count", 40'(got), 40'd8);
    check("stream_left", 40'(exp_q.size()), 40'd0);
    check("stream_sum", e, 40'd240);

    // Reset with two commands in flight.
    run_cmd(NOP, 16'h0000, 16'h0000, 1'b1, d, o, lat);
    @(negedge clk);
    cmd_in = ADM1; m1_in = 16'h0005; in_valid = 1'b1;
    @(negedge clk);
    m1_in = 16'h0006;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_d", d_out, 40'h0000000005);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 40'(out_valid), 40'd0);
    check("mid_rst_d", d_out, 40'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    got = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (out_valid || d_out != 40'd0) got++;
    end
    check("post_rst_quiet", 40'(got), 40'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_alu_pipe.md
Name: mac_alu_pipe

Overview:
Two-stage pipelined, width-parametrised successor of the filter datapath ALU. It keeps the accumulator internally instead of taking it as an input, and adds valid/ready flow control, synchronous accumulator clear and a sticky overflow flag. It executes the existing alu_cmd_t command set (NOP, M1, M2, MU, ACN, M1N, M2N, MUN, ADAC, ADM1, ADM2, ADMU, SUAC, SUM1, SUM2, SUMU, SATA) and sits between the filter controller and the coefficient/sample memories.

Parameters:
DATABITS, 16, operand width, signed two's complement.
ACCBITS, 40, accumulator width; elaboration error if ACCBITS < 2*DATABITS+1.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  command/operands valid
in_ready  out  1  pipe can accept this cycle
cmd_in  in  alu_cmd_t  operation
m1_in  in  DATABITS  signed operand 1
m2_in  in  DATABITS  signed operand 2
clr_in  in  1  synchronous accumulator and overflow clear
out_valid  out  1  d_out holds a newly retired result
out_ready  in  1  consumer accepts d_out
d_out  out  ACCBITS  accumulator (result register)
ovf_out  out  1  sticky signed-overflow flag

Behaviour:
- Reset: all stage registers 0, out_valid=0, d_out=0, ovf_out=0. Reset mid-operation discards all in-flight commands.
- Pipeline enable: en = !(out_valid && !out_ready). in_ready = en, combinational, with no dependency on in_valid.
- Stage 1, captured when en: s1_valid<=in_valid && in_ready; cmd, m1, m2 registered; product p = signed m1*m2 (2*DATABITS) registered.
- Stage 2, when en: out_valid<=s1_valid. If s1_valid, the acc (d_out) register is updated with f(cmd, acc, m1, m2, p).
- Latency: result visible 2 cycles after acceptance. Throughput is 1/cycle with no bubbles; back-to-back accumulate needs no forwarding because stage 2 reads its own register.
- Arithmetic:
  - Operands and product are sign-extended to ACCBITS; results wrap modulo 2^ACCBITS.
  - NOP keeps acc.
  - ADAC=acc+acc. SUAC=0. ACN=-acc.
  - xN commands negate the operand or product.
  - ADx=acc+x. SUx=acc-x.
- Overflow: the exact result is computed at ACCBITS+2 bits. If it does not fit ACCBITS signed (e.g. -min, acc+acc wrap), ovf_out<=1 on retire. The flag stays set until clr_in or reset.
- SATA: ip=acc[2*DATABITS-2:DATABITS-1] and op=acc[ACCBITS-1:2*DATABITS-2].
  - Positive acc with |op: result 0x7FF..F.
  - Negative acc with !&op: result 0x800..0.
  - Otherwise: result ip.
  - The result is sign-extended to ACCBITS and written back to acc. SATA never sets ovf.
- clr_in: when asserted with en, acc<=0 and ovf<=0 at the same edge. If s1_valid also retires that cycle, the command operates on acc=0; e.g. clr+ADMU loads the product.
- Stall: while !en, every register holds and in_ready=0. d_out and out_valid stay stable until out_ready.

Optional Feature:
ALU_ROUND_EN.
- Defined: SATA first adds 2^(DATABITS-2) to acc at ACCBITS+1 bits, i.e. round half up, then saturates. A rounding carry into op saturates positive.
- Undefined: SATA truncates, as specified above.

Decomposition:
- myfilter_pkg keeps alu_cmd_t unchanged and gains a function sat_q(acc, round) usable by RTL and SVA.
- Natural sub-module: mac_alu_sat, the combinational SATA saturation/rounding unit, instantiated in stage 2.
- Companion checker mac_alu_pipe_svamod:
  - X-checks.
  - Latency-2 reference model.
  - Stall-stability property.

Test Plan (DATABITS=16, ACCBITS=40):
- Reset then clr; ADMU m1=0x0003 m2=0xFFFE -> d_out=-6 (0xFFFFFFFFFA) 2 cycles later; then ADM1 m1=0x0010 next cycle -> d_out=10, ovf_out=0.
- Load acc=2^30 via repeated ADMU; SATA -> d_out=0x0000007FFF. Load acc=-2^31; SATA -> d_out=0xFFFFFF8000. Load acc=0x18000; SATA -> d_out=3.
- M1N with acc chain reaching -2^39, then ACN -> d_out=0x8000000000 (wrap) and ovf_out=1; flag stays set until clr_in.
- Stream 8 ADMU with out_ready low for cycles 3-5 -> in_ready low, d_out stable, no command lost or duplicated; final sum matches model.
- With ALU_ROUND_EN, acc=0x4000 then SATA -> d_out=1; without the macro -> d_out=0.
- Assert rst_n low while 2 commands are in flight -> out_valid=0 and d_out=0 immediately; no retire after release.
